// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file debug dump sequencer.
package regfile_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HDR,
    ST_DATA,
    ST_DONE,
    ST_ABORTED
  } state_e;

  // Upper three bits of every header byte; the low five carry the index.
  localparam logic [2:0] HDR_TAG = 3'b101;

  localparam int REG_IDX_W     = 5;
  localparam int DEFAULT_WIDTH = 32;

  // Bytes streamed per register for a given data width.
  function automatic int bytes_per_reg(input int width);
    return width / 8;
  endfunction

  localparam int BYTES_PER_REG = bytes_per_reg(DEFAULT_WIDTH);

endpackage

// File: rtl/dump_byte_shifter.sv
// Capture register for one register-file word, streamed MSB byte first.
module dump_byte_shifter
  import regfile_dump_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [7:0]       cur_byte_o,
  output logic [7:0]       next_byte_o,
  output logic             last_byte_o
);

  localparam int BPR   = bytes_per_reg(WIDTH);
  localparam int CNT_W = $clog2(BPR + 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load a fresh word with a full byte count, or drop the top byte on shift.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = data_i;
      cnt_d   = CNT_W'(BPR);
    end else if (shift_i) begin
      shreg_d = shreg_q << 8;
      cnt_d   = cnt_q - CNT_W'(1);
    end
  end

  // Capture register and remaining-byte counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cur_byte_o  = shreg_q[WIDTH-1 -: 8];
  assign last_byte_o = (cnt_q == CNT_W'(1));

  // The byte that becomes current after the next shift, so the top level
  // can register it into tx_data in the same edge.
  generate
    if (WIDTH > 8) begin : g_next
      assign next_byte_o = shreg_q[WIDTH-9 -: 8];
    end else begin : g_single
      assign next_byte_o = 8'h00;
    end
  endgenerate

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Debug-dump sequencer: walks a register index range through the register
// file debug port and streams header + data bytes on a valid/ready port.
module regfile_dump_ctrl
  import regfile_dump_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [REG_IDX_W-1:0] first_reg_i,
  input  logic [REG_IDX_W-1:0] last_reg_i,
  output logic [REG_IDX_W-1:0] dbg_sel_o,
  input  logic [WIDTH-1:0]     dbg_data_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 aborted_o
);

  state_e               state_q, state_d;
  logic [REG_IDX_W-1:0] idx_q, idx_d;
  logic [REG_IDX_W-1:0] last_q, last_d;
  logic [REG_IDX_W-1:0] dbg_sel_q, dbg_sel_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 abort_q, abort_d;
  logic                 tx_valid_q, busy_q, done_q, aborted_q;

  logic       sh_load, sh_shift, sh_last;
  logic [7:0] sh_cur, sh_next;
  logic       hs, abort_now;

  dump_byte_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (sh_load),
    .shift_i     (sh_shift),
    .data_i      (dbg_data_i),
    .cur_byte_o  (sh_cur),
    .next_byte_o (sh_next),
    .last_byte_o (sh_last)
  );

  assign hs        = tx_valid_q & tx_ready_i;
  assign abort_now = abort_q | abort_i;

  // Next-state, index, abort flag and next output byte.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    abort_d   = abort_q;
    dbg_sel_d = dbg_sel_q;
    tx_data_d = tx_data_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start_i) begin
          idx_d   = first_reg_i;
          last_d  = last_reg_i;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        abort_d = abort_now;
        if (abort_now) begin
          state_d = ST_ABORTED;
        end else begin
          sh_load   = 1'b1;
          tx_data_d = {HDR_TAG, idx_q};
          state_d   = ST_HDR;
        end
      end
      ST_HDR: begin
        abort_d = abort_now;
        if (hs) begin
          if (abort_now) begin
            state_d = ST_ABORTED;
          end else begin
            tx_data_d = sh_cur;
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        abort_d = abort_now;
        if (hs) begin
          // Completing the final register wins over a coincident abort.
          if (sh_last && idx_q == last_q) begin
            state_d = ST_DONE;
          end else if (abort_now) begin
            state_d = ST_ABORTED;
          end else if (sh_last) begin
            idx_d   = idx_q + REG_IDX_W'(1);
            state_d = ST_LOAD;
          end else begin
            sh_shift  = 1'b1;
            tx_data_d = sh_next;
          end
        end
      end
      ST_DONE, ST_ABORTED: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Debug select is registered, so present the index on entry to LOAD.
    if (state_d == ST_LOAD) dbg_sel_d = idx_d;
  end

  // State, datapath registers and registered outputs decoded from next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      abort_q    <= 1'b0;
      dbg_sel_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      abort_q    <= abort_d;
      dbg_sel_q  <= dbg_sel_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= (state_d == ST_HDR) || (state_d == ST_DATA);
      busy_q     <= (state_d == ST_LOAD) || (state_d == ST_HDR) || (state_d == ST_DATA);
      done_q     <= (state_d == ST_DONE);
      aborted_q  <= (state_d == ST_ABORTED);
    end
  end

  assign dbg_sel_o  = dbg_sel_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign aborted_o  = aborted_q;

endmodule
